// File: rtl/snes_pad_pkg.sv
// Shared definitions for the SNES-style gamepad reader: button indices,
// protocol constants and the reader's state encoding.
package snes_pad_pkg;

  localparam int SNES_BITS = 16;
  localparam int NUM_BTNS  = 12;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_CLK_LOW  = 3'd2,
    ST_CLK_HIGH = 3'd3,
    ST_DONE     = 3'd4
  } snes_state_t;

  // A real pad always drives its four trailing bits high (released);
  // the board pull-down makes an empty port read all-zero.
  function automatic logic pad_present(input logic [SNES_BITS-1:0] raw);
    return (raw[SNES_BITS-1:SNES_BITS-4] == 4'b1111);
  endfunction

endpackage

// File: rtl/snes_pad_reader.sv
// Once-per-frame SNES pad poller: latches the pad, shifts in 16 active-low
// bits, and publishes two-poll debounced active-high button levels.
module snes_pad_reader
  import snes_pad_pkg::*;
#(
  parameter int CLK_DIV = 150
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_poll,
  input  logic                i_pad_data,
  output logic                o_pad_latch,
  output logic                o_pad_clk,
  output logic [NUM_BTNS-1:0] o_buttons,
  output logic                o_up,
  output logic                o_down,
  output logic                o_left,
  output logic                o_right,
  output logic                o_pause,
  output logic                o_restart,
  output logic                o_present,
  output logic                o_busy,
  output logic                o_valid
);

  localparam int CNT_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);

  snes_state_t            r_state;
  snes_state_t            w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_idx;
  logic [SNES_BITS-1:0]   r_raw;
  logic [NUM_BTNS-1:0]    r_prev_cand;
  logic [NUM_BTNS-1:0]    r_buttons;
  logic                   r_present;
  logic                   r_poll_d;
  logic                   r_data_s1;
  logic                   r_data_s2;
  logic                   r_pad_latch;
  logic                   r_pad_clk;
  logic                   r_busy;
  logic                   r_valid;

  logic                   w_poll_edge;
  logic                   w_cnt_last;
  logic                   w_enter_done;
  logic                   w_present;
  logic [NUM_BTNS-1:0]    w_cand;
  logic                   w_latch;
  logic                   w_pclk;
  logic                   w_busy;
  logic                   w_valid;

  assign w_poll_edge  = i_poll & ~r_poll_d;
  assign w_cnt_last   = (r_state == ST_LATCH) ? (r_cnt == LATCH_LAST) : (r_cnt == HALF_LAST);
  assign w_enter_done = (r_state == ST_CLK_HIGH) && (w_state_next == ST_DONE);
  assign w_present    = pad_present(r_raw);
  assign w_cand       = ~r_raw[NUM_BTNS-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; poll edges outside IDLE are dropped, not queued
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     w_state_next = w_poll_edge ? ST_LATCH : ST_IDLE;
      ST_LATCH:    w_state_next = w_cnt_last ? ST_CLK_LOW : ST_LATCH;
      ST_CLK_LOW:  w_state_next = w_cnt_last ? ST_CLK_HIGH : ST_CLK_LOW;
      ST_CLK_HIGH: begin
        if (w_cnt_last) begin
          w_state_next = (r_idx == 4'd15) ? ST_DONE : ST_CLK_LOW;
        end else begin
          w_state_next = ST_CLK_HIGH;
        end
      end
      ST_DONE:     w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the pad lines come straight off flops
  always_comb begin
    w_latch = 1'b0;
    w_pclk  = 1'b1;
    w_busy  = 1'b1;
    w_valid = 1'b0;
    case (w_state_next)
      ST_IDLE:     w_busy  = 1'b0;
      ST_LATCH:    w_latch = 1'b1;
      ST_CLK_LOW:  w_pclk  = 1'b0;
      ST_CLK_HIGH: w_pclk  = 1'b1;
      ST_DONE:     w_valid = 1'b1;
      default:     w_busy  = 1'b0;
    endcase
  end

  // Registered protocol and status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b1;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_pad_latch <= w_latch;
      r_pad_clk   <= w_pclk;
      r_busy      <= w_busy;
      r_valid     <= w_valid;
    end
  end

  // Input conditioning, bit timing, shift register and debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_poll_d    <= 1'b0;
      r_data_s1   <= 1'b0;
      r_data_s2   <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= 4'd0;
      r_raw       <= '0;
      r_prev_cand <= '0;
      r_buttons   <= '0;
      r_present   <= 1'b0;
    end else begin
      r_poll_d  <= i_poll;
      r_data_s1 <= i_pad_data;
      r_data_s2 <= r_data_s1;

      if ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state != w_state_next)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (r_state == ST_LATCH) begin
        r_idx <= 4'd0;
      end else if ((r_state == ST_CLK_HIGH) && w_cnt_last) begin
        r_idx <= r_idx + 4'd1;
      end

      // Sample at the end of the low phase; the pad changes data on the rising edge
      if ((r_state == ST_CLK_LOW) && w_cnt_last) begin
        r_raw[r_idx] <= r_data_s2;
      end

      // Buttons commit only when two consecutive polls agree; loss of pad clears at once
      if (w_enter_done) begin
        r_present   <= w_present;
        r_prev_cand <= w_cand;
        if (!w_present) begin
          r_buttons <= '0;
        end else if (w_cand == r_prev_cand) begin
          r_buttons <= w_cand;
        end
      end
    end
  end

  assign o_pad_latch = r_pad_latch;
  assign o_pad_clk   = r_pad_clk;
  assign o_busy      = r_busy;
  assign o_valid     = r_valid;
  assign o_buttons   = r_buttons;
  assign o_present   = r_present;
  assign o_up        = r_buttons[BTN_UP];
  assign o_down      = r_buttons[BTN_DOWN];
  assign o_left      = r_buttons[BTN_LEFT];
  assign o_right     = r_buttons[BTN_RIGHT];
  assign o_pause     = r_buttons[BTN_START];
  assign o_restart   = r_buttons[BTN_SELECT];

endmodule
